regfile_wb_ctrl: RTL and testbench

Write-back controller for the multi-cycle CPU. It is the writer side of the register file's single write port. It accepts write-back requests from the datapath, selects the result source, and buffers requests in a small FIFO. It then drives the register file's L_S / Wt_addr / Wt_data port one write per cycle and keeps a busy scoreboard so the control unit can stall on pending destinations.

---
 rtl/regfile_wb_ctrl.sv | 128 ++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: buffers register-file writes in a FIFO, drains one per cycle,
// and tracks pending destinations. Define WB_FWD_EN to enable the forwarding lookup.
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reserve_en,
  input  logic [4:0]  reserve_addr,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_addr,
  input  logic [1:0]  wb_sel,
  input  logic [31:0] alu_res,
  input  logic [31:0] mem_data,
  input  logic [31:0] pc4,
  input  logic [31:0] imm_u,
  output logic        L_S,
  output logic [4:0]  Wt_addr,
  output logic [31:0] Wt_data,
  input  logic [4:0]  q_addr_A,
  input  logic [4:0]  q_addr_B,
  output logic        busy_A,
  output logic        busy_B,
  output logic        fwd_hit_A,
  output logic        fwd_hit_B,
  output logic [31:0] fwd_data_A,
  output logic [31:0] fwd_data_B
);

  logic [4:0]    q_a [DEPTH];
  logic [31:0]   q_d [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [31:0]   sel_data;
  logic [31:0]   sb, sb_nxt;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wb_ready = !full && !rst;
  // r0 requests complete the handshake but never occupy an entry
  assign push     = wb_valid && wb_ready && (wb_addr != 5'd0);
  assign pop      = !empty;

  always_comb begin
    sel_data = alu_res;
    case (wb_sel)
      2'd1:    sel_data = mem_data;
      2'd2:    sel_data = pc4;
      2'd3:    sel_data = imm_u;
      default: sel_data = alu_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_a[wr_ptr] <= wb_addr;
      q_d[wr_ptr] <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      L_S     <= 1'b0;
      Wt_addr <= '0;
      Wt_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        L_S     <= 1'b1;
        Wt_addr <= q_a[rd_ptr];
        Wt_data <= q_d[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end else begin
        L_S     <= 1'b0;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Commit clears first so a same-edge reservation survives
  always_comb begin
    sb_nxt = sb;
    if (L_S) sb_nxt[Wt_addr] = 1'b0;
    if (reserve_en) sb_nxt[reserve_addr] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= sb_nxt;
  end

  assign busy_A = sb[q_addr_A];
  assign busy_B = sb[q_addr_B];

`ifdef WB_FWD_EN
  // Scan oldest to newest so the youngest match wins; output stage is lowest priority
  function automatic logic [32:0] fwd_lookup(input logic [4:0] q);
    logic [32:0]   r;
    logic [AW-1:0] idx;
    r = {L_S && (Wt_addr == q), Wt_data};
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if (((AW+1)'(k) < count) && (q_a[idx] == q)) r = {1'b1, q_d[idx]};
    end
    if (q == 5'd0) r = '0;
    if (!r[32]) r[31:0] = '0;
    return r;
  endfunction

  always_comb begin
    {fwd_hit_A, fwd_data_A} = fwd_lookup(q_addr_A);
    {fwd_hit_B, fwd_data_B} = fwd_lookup(q_addr_B);
  end
`else
  assign fwd_hit_A  = 1'b0;
  assign fwd_hit_B  = 1'b0;
  assign fwd_data_A = '0;
  assign fwd_data_B = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: queue-based reference model, decoupled monitor.
module tb_regfile_wb_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reserve_en = 1'b0;
  logic [4:0]  reserve_addr = '0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_addr = '0;
  logic [1:0]  wb_sel = '0;
  logic [31:0] alu_res = '0, mem_data = '0, pc4 = '0, imm_u = '0;
  logic        L_S;
  logic [4:0]  Wt_addr;
  logic [31:0] Wt_data;
  logic [4:0]  q_addr_A = '0, q_addr_B = '0;
  logic        busy_A, busy_B, fwd_hit_A, fwd_hit_B;
  logic [31:0] fwd_data_A, fwd_data_B;

  regfile_wb_ctrl #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst), .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_sel(wb_sel),
    .alu_res(alu_res), .mem_data(mem_data), .pc4(pc4), .imm_u(imm_u),
    .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
    .q_addr_A(q_addr_A), .q_addr_B(q_addr_B), .busy_A(busy_A), .busy_B(busy_B),
    .fwd_hit_A(fwd_hit_A), .fwd_hit_B(fwd_hit_B),
    .fwd_data_A(fwd_data_A), .fwd_data_B(fwd_data_B)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];     // model FIFO contents
  ent_t        exp_q[$];  // writes still expected on the register-file port
  logic        mo_v = 1'b0;
  logic [4:0]  mo_a = '0;
  logic [31:0] mo_d = '0;
  logic [31:0] bm = '0;
  logic        seen_rst = 1'b0;
  int          checks = 0, errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s);
    case (s)
      2'd0: return alu_res;
      2'd1: return mem_data;
      2'd2: return pc4;
      default: return imm_u;
    endcase
  endfunction

  // Reference: newest queued write, else the one on the port this cycle
  function automatic logic [32:0] ref_fwd(input logic [4:0] q);
`ifdef WB_FWD_EN
    if (q == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == q) return {1'b1, mq[i].d};
    if (mo_v && mo_a == q) return {1'b1, mo_d};
`endif
    return '0;
  endfunction

  always @(posedge clk) begin
    ent_t e;
    bit   rdy;
    if (rst) begin
      mq.delete(); exp_q.delete();
      mo_v = 1'b0; mo_a = '0; mo_d = '0; bm = '0; seen_rst = 1'b1;
    end else begin
      rdy = mq.size() < DEPTH;
      if (mo_v) bm[mo_a] = 1'b0;
      if (reserve_en && reserve_addr != 5'd0) bm[reserve_addr] = 1'b1;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        mo_v = 1'b1; mo_a = e.a; mo_d = e.d;
      end else mo_v = 1'b0;
      if (wb_valid && rdy && wb_addr != 5'd0) begin
        e.a = wb_addr; e.d = pick(wb_sel);
        mq.push_back(e); exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] fa, fb;
    ent_t        e;
    if (seen_rst) begin
      fa = ref_fwd(q_addr_A);
      fb = ref_fwd(q_addr_B);
      chk("L_S", 32'(L_S), 32'(mo_v));
      chk("Wt_addr", 32'(Wt_addr), 32'(mo_a));
      chk("Wt_data", Wt_data, mo_d);
      chk("wb_ready", 32'(wb_ready), 32'((mq.size() < DEPTH) && !rst));
      chk("busy_A", 32'(busy_A), 32'(bm[q_addr_A]));
      chk("busy_B", 32'(busy_B), 32'(bm[q_addr_B]));
      chk("fwd_hit_A", 32'(fwd_hit_A), 32'(fa[32]));
      chk("fwd_data_A", fwd_data_A, fa[31:0]);
      chk("fwd_hit_B", 32'(fwd_hit_B), 32'(fb[32]));
      chk("fwd_data_B", fwd_data_B, fb[31:0]);
      if (L_S === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_write: got addr %h data %h expected none", Wt_addr, Wt_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_addr", 32'(Wt_addr), 32'(e.a));
          chk("sb_data", Wt_data, e.d);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [4:0] a, input logic [1:0] s, input logic [31:0] alu);
    int n = 0;
    wb_valid = 1'b1; wb_addr = a; wb_sel = s; alu_res = alu;
    while (!wb_ready && n < 20) begin step(); n++; end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got wb_ready 0 expected 1 within 20 cycles");
    end
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q_addr_A = 5'(i); q_addr_B = 5'(i + 16); step();
    end
    // single write with reservation
    q_addr_A = 5'd5; q_addr_B = 5'd0;
    reserve_en = 1'b1; reserve_addr = 5'd5; step(); reserve_en = 1'b0;
    send(5'd5, 2'd0, 32'h1234);
    step(3);
    // back-to-back with every source
    pc4 = 32'h40; imm_u = 32'hABCD0000; mem_data = 32'hDEAD;
    q_addr_A = 5'd3; q_addr_B = 5'd4;
    for (int i = 1; i <= 5; i++) send(5'(i), 2'(i % 4), 32'h100 + 32'(i));
    step(3);
    // r0 write is swallowed
    q_addr_A = 5'd0;
    send(5'd0, 2'd0, 32'hFFFF);
    step(3);
    // reservation coincident with the r7 commit
    q_addr_A = 5'd7;
    reserve_en = 1'b1; reserve_addr = 5'd7; step(); reserve_en = 1'b0;
    send(5'd7, 2'd0, 32'h77);
    step();
    reserve_en = 1'b1; reserve_addr = 5'd7; step(); reserve_en = 1'b0;
    step(2);
    // two writes to r9, newest must forward
    q_addr_A = 5'd9; q_addr_B = 5'd7;
    send(5'd9, 2'd0, 32'h11);
    send(5'd9, 2'd0, 32'h22);
    step(3);
    // reset with writes in flight
    q_addr_A = 5'd11; q_addr_B = 5'd12;
    reserve_en = 1'b1; reserve_addr = 5'd11; step(); reserve_en = 1'b0;
    wb_valid = 1'b1; wb_sel = 2'd0;
    for (int i = 10; i <= 12; i++) begin wb_addr = 5'(i); alu_res = 32'(i); step(); end
    wb_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    step(4);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      wb_valid     = 1'($urandom_range(0, 1));
      wb_addr      = 5'($urandom_range(0, 7));
      wb_sel       = 2'($urandom);
      alu_res      = $urandom; mem_data = $urandom; pc4 = $urandom; imm_u = $urandom;
      reserve_en   = 1'($urandom_range(0, 1));
      reserve_addr = 5'($urandom_range(0, 7));
      q_addr_A     = 5'($urandom_range(0, 7));
      q_addr_B     = 5'($urandom_range(0, 7));
      rst          = ($urandom_range(0, 99) == 0);
      step();
    end
    wb_valid = 1'b0; reserve_en = 1'b0; rst = 1'b0;
    step(4);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
